// File: rtl/sdes_decrypt_seq.sv
// Multi-cycle S-DES decryption engine with valid/ready handshakes on both sides.
// The sequence is latch, key schedule, round with K2, round with K1, then hold the result.
module sdes_decrypt_seq #(
    parameter bit CLEAR_ON_POP = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  ciphertext,
    input  logic [9:0]  key,
    input  logic [31:0] S0,
    input  logic [31:0] S1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  decryptedtext,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KSCHED = 3'd1,
        RND1   = 3'd2,
        RND2   = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  dt_q, dt_d;
    logic [7:0]  ct_q, ct_d;
    logic [9:0]  key_q, key_d;
    logic [31:0] s0_q, s0_d;
    logic [31:0] s1_q, s1_d;
    logic [7:0]  k1_q, k1_d;
    logic [7:0]  k2_q, k2_d;
    logic [7:0]  data_q, data_d;

    // Permutation position p of an n-bit vector is bit n-p.
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] v);
        return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] b);
        return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] b);
        return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [1:0] sbox(input logic [31:0] s, input logic [3:0] b);
        logic [3:0] idx;
        idx = {b[3], b[0], b[2], b[1]};
        return s[{idx, 1'b0} +: 2];
    endfunction

    function automatic logic [7:0] fk(input logic [7:0] x, input logic [7:0] k,
                                      input logic [31:0] sb0, input logic [31:0] sb1);
        logic [7:0] t;
        logic [3:0] s;
        t = ep(x[3:0]) ^ k;
        s = {sbox(sb0, t[7:4]), sbox(sb1, t[3:0])};
        return {x[7:4] ^ p4(s), x[3:0]};
    endfunction

    // Returns {K1, K2}: rotate halves by 1 for K1, by a further 2 for K2.
    function automatic logic [15:0] key_sched(input logic [9:0] k);
        logic [9:0] p;
        logic [4:0] l1, r1, l2, r2;
        p  = p10(k);
        l1 = {p[8:5], p[9]};
        r1 = {p[3:0], p[4]};
        l2 = {l1[2:0], l1[4:3]};
        r2 = {r1[2:0], r1[4:3]};
        return {p8({l1, r1}), p8({l2, r2})};
    endfunction

    // Next-state and datapath decode for the decryption sequence.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        dt_d        = dt_q;
        ct_d        = ct_q;
        key_d       = key_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    ct_d       = ciphertext;
                    key_d      = key;
                    s0_d       = S0;
                    s1_d       = S1;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = KSCHED;
                end else begin
                    state_d = IDLE;
                end
            end
            KSCHED: begin
                {k1_d, k2_d} = key_sched(key_q);
                state_d      = RND1;
            end
            RND1: begin
                data_d  = fk(ip(ct_q), k2_q, s0_q, s1_q);
                data_d  = {data_d[3:0], data_d[7:4]};
                state_d = RND2;
            end
            RND2: begin
                dt_d        = ip_inv(fk(data_q, k1_q, s0_q, s1_q));
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                    if (CLEAR_ON_POP) begin
                        dt_d = 8'h00;
                    end else begin
                        dt_d = dt_q;
                    end
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            dt_q        <= 8'h00;
            ct_q        <= 8'h00;
            key_q       <= 10'h000;
            s0_q        <= 32'h0000_0000;
            s1_q        <= 32'h0000_0000;
            k1_q        <= 8'h00;
            k2_q        <= 8'h00;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            dt_q        <= dt_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            data_q      <= data_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign busy          = busy_q;
    assign decryptedtext = dt_q;

endmodule

// File: tb/tb_sdes_decrypt_seq.sv
// Directed bench for sdes_decrypt_seq: the classic S-DES vector plus model-encrypted
// blocks fed back-to-back, backpressure, mid-flight reset and the clear-on-pop variant.
module tb_sdes_decrypt_seq;

    localparam logic [31:0] S0_STD = 32'hB7D81BB1;
    localparam logic [31:0] S1_STD = 32'hC613D2E4;
    localparam logic [9:0]  KEY_A  = 10'b1010000010;
    localparam logic [7:0]  CT_A   = 8'h38;
    localparam logic [7:0]  PT_A   = 8'h97;

    localparam int P10_T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    localparam int P8_T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    localparam int IP_T[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    localparam int IPI_T[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    localparam int EP_T[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    localparam int P4_T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_valid_c = 1'b0;
    logic        out_ready = 1'b1, out_ready_c = 1'b1;
    logic [7:0]  ct = 8'h00;
    logic [9:0]  key_in = 10'h000;
    logic [31:0] s0 = S0_STD, s1 = S1_STD;
    logic        in_ready, out_valid, busy;
    logic        in_ready_c, out_valid_c, busy_c;
    logic [7:0]  dt, dt_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sdes_decrypt_seq #(.CLEAR_ON_POP(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ciphertext(ct), .key(key_in), .S0(s0), .S1(s1),
        .out_valid(out_valid), .out_ready(out_ready), .decryptedtext(dt), .busy(busy)
    );

    sdes_decrypt_seq #(.CLEAR_ON_POP(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .ciphertext(ct), .key(key_in), .S0(s0), .S1(s1),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .decryptedtext(dt_c), .busy(busy_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Table-driven permutation model: output position i takes input position tbl[i].
    function automatic logic [9:0] perm(input logic [9:0] v, input int n_in,
                                        input int tbl[10], input int n_out);
        logic [9:0] r;
        r = 10'h000;
        for (int i = 0; i < n_out; i++) r[n_out-1-i] = v[n_in-tbl[i]];
        return r;
    endfunction

    function automatic logic [1:0] sbox_m(input logic [31:0] s, input logic [3:0] b);
        int row, col;
        logic [31:0] sh;
        row = 2 * int'(b[3]) + int'(b[0]);
        col = 2 * int'(b[2]) + int'(b[1]);
        sh  = s >> (2 * (4 * row + col));
        return sh[1:0];
    endfunction

    function automatic logic [7:0] fk_m(input logic [7:0] x, input logic [7:0] k);
        logic [9:0] e, p;
        logic [7:0] t;
        logic [3:0] s;
        e = perm({6'b000000, x[3:0]}, 4, EP_T, 8);
        t = e[7:0] ^ k;
        s = {sbox_m(S0_STD, t[7:4]), sbox_m(S1_STD, t[3:0])};
        p = perm({6'b000000, s}, 4, P4_T, 4);
        return {x[7:4] ^ p[3:0], x[3:0]};
    endfunction

    function automatic logic [7:0] encrypt_m(input logic [7:0] pt, input logic [9:0] k);
        logic [9:0] p, a, b, y;
        logic [4:0] l, r;
        logic [7:0] k1, k2, z;
        p  = perm(k, 10, P10_T, 10);
        l  = {p[8:5], p[9]};
        r  = {p[3:0], p[4]};
        a  = perm({l, r}, 10, P8_T, 8);
        k1 = a[7:0];
        l  = {l[2:0], l[4:3]};
        r  = {r[2:0], r[4:3]};
        b  = perm({l, r}, 10, P8_T, 8);
        k2 = b[7:0];
        y  = perm({2'b00, pt}, 8, IP_T, 8);
        z  = fk_m(y[7:0], k1);
        z  = fk_m({z[3:0], z[7:4]}, k2);
        y  = perm({2'b00, z}, 8, IPI_T, 8);
        return y[7:0];
    endfunction

    task automatic send(input logic [7:0] c, input logic [9:0] k);
        ct = c;
        key_in = k;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int lat, cyc, idx, oidx, last, seen;
        logic acc;
        logic [7:0] pts[20];
        logic [9:0] keys[20];
        logic [7:0] pt_b;
        logic [9:0] key_b;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_dt", {24'd0, dt}, 32'h00);
        check_eq("rst_dt_c", {24'd0, dt_c}, 32'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: classic vector, consumer always ready.
        send(CT_A, KEY_A);
        check_eq("s1_in_ready_busy", {30'd0, in_ready, busy}, 32'd1);
        wait_valid(lat);
        check_eq("s1_latency", lat, 32'd3);
        check_eq("s1_dt", {24'd0, dt}, {24'd0, PT_A});
        check_eq("s1_in_ready_out", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check_eq("s1_pop_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("s1_pop_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("s1_pop_busy", {31'd0, busy}, 32'd0);
        check_eq("s1_dt_held", {24'd0, dt}, {24'd0, PT_A});

        // Scenario 2: backpressure for 10 cycles.
        out_ready = 1'b0;
        send(CT_A, KEY_A);
        wait_valid(lat);
        check_eq("s2_latency", lat, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("s2_hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("s2_hold_dt", {24'd0, dt}, {24'd0, PT_A});
            check_eq("s2_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("s2_pop_valid", {31'd0, out_valid}, 32'd0);
        check_eq("s2_pop_in_ready", {31'd0, in_ready}, 32'd1);

        // Scenario 3: inputs change right after accept.
        send(CT_A, KEY_A);
        ct = 8'hFF;
        key_in = 10'h155;
        s0 = 32'h0000_0000;
        s1 = 32'hFFFF_FFFF;
        wait_valid(lat);
        check_eq("s3_dt", {24'd0, dt}, {24'd0, PT_A});
        s0 = S0_STD;
        s1 = S1_STD;
        @(posedge clk); #1;

        // Scenario 4: twenty model-encrypted blocks, in_valid held high.
        for (int i = 0; i < 20; i++) begin
            pts[i]  = 8'($urandom_range(255, 0));
            keys[i] = 10'($urandom_range(1023, 0));
        end
        idx = 0; oidx = 0; cyc = 0; last = 0;
        ct = encrypt_m(pts[0], keys[0]);
        key_in = keys[0];
        in_valid = 1'b1;
        while (oidx < 20 && cyc < 300) begin
            if (out_valid) begin
                check_eq("s4_pt", {24'd0, dt}, {24'd0, pts[oidx]});
                oidx++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx > 0) check_eq("s4_gap", cyc - last, 32'd5);
                last = cyc;
                idx++;
                if (idx < 20) begin
                    ct = encrypt_m(pts[idx], keys[idx]);
                    key_in = keys[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check_eq("s4_count", oidx, 32'd20);
        @(posedge clk); #1;

        // Scenario 5: reset while the block is in RND1.
        pt_b = 8'h5A;
        key_b = 10'h2C7;
        send(encrypt_m(8'hC3, 10'h1F0), 10'h1F0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("s5_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("s5_rst_dt", {24'd0, dt}, 32'h00);
        check_eq("s5_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("s5_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("s5_aborted_seen", seen, 32'd0);
        send(encrypt_m(pt_b, key_b), key_b);
        wait_valid(lat);
        check_eq("s5_next_latency", lat, 32'd3);
        check_eq("s5_next_dt", {24'd0, dt}, {24'd0, pt_b});
        @(posedge clk); #1;

        // Scenario 6: clear-on-pop instance.
        ct = CT_A;
        key_in = KEY_A;
        in_valid_c = 1'b1;
        @(posedge clk); #1;
        in_valid_c = 1'b0;
        cyc = 0;
        while (!out_valid_c && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("s6_latency", cyc, 32'd3);
        check_eq("s6_dt_out", {24'd0, dt_c}, {24'd0, PT_A});
        @(posedge clk); #1;
        check_eq("s6_dt_cleared", {24'd0, dt_c}, 32'h00);
        check_eq("s6_pop_valid", {31'd0, out_valid_c}, 32'd0);
        check_eq("s6_pop_in_ready", {31'd0, in_ready_c}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
